irq_ctrl4: RTL and testbench
============================

Name: irq_ctrl4

Overview:
- 4-line interrupt request controller that sits directly upstream of the 4-to-2 priority encoder.
- Synchronises asynchronous request lines and latches them as pending, per-line edge or level.
- Applies a mask, then presents the priority-encoded winner to the CPU over an irq_req/irq_ack/eoi handshake.
- Line 3 has the highest priority, line 0 the lowest.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per irq_in line (legal range 2..3).
- EDGE_MASK, 4'b0000, per-line trigger mode: 1 = rising-edge-triggered, 0 = level-triggered.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- irq_in  input  4  asynchronous interrupt request lines
- mask  input  4  1 = line disabled for arbitration; pending bits still latch
- irq_ack  input  1  CPU acknowledges the presented request (single-cycle pulse)
- eoi  input  1  CPU end-of-interrupt (single-cycle pulse)
- irq_req  output  1  request to CPU
- irq_id  output  2  encoded id of the presented line, 3 = highest priority
- busy  output  1  an acknowledged interrupt is in service
- pending  output  4  current pending register, for status readback

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-handshake):
  - All synchroniser flops, edge-detect flops and pending are cleared to 0.
  - FSM returns to IDLE.
  - irq_req=0, irq_id=2'b00, busy=0, pending=4'b0000.
- Synchroniser:
  - SYNC_STAGES-flop chain per line; its output is s[3:0].
  - A previous-value flop p[3:0] follows s.
- Pending, edge lines (EDGE_MASK[i]=1):
  - pending[i] is set when s[i]=1 and p[i]=0.
  - It is cleared on the cycle irq_ack is accepted with irq_id==i.
  - Set and clear in the same cycle: set wins, so the new edge is not lost.
- Pending, level lines:
  - pending[i] <= s[i] every cycle; irq_ack has no effect on it.
- Latency: irq_in rising before clock edge k gives:
  - s high after edge k+SYNC_STAGES-1.
  - pending high after edge k+SYNC_STAGES.
  - irq_req high after edge k+SYNC_STAGES+1 if the FSM is in IDLE (3 cycles at default).
- eligible = pending & ~mask.
- The winner is the highest-index set bit of eligible; "none" if eligible is zero.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible is nonzero, latch the winner into irq_id and go to REQ.
  - REQ: irq_req=1; irq_id is held stable with no preemption, even if a higher line or a mask change arrives.
    - On irq_ack: clear the edge-pending bit per the rules above and go to SERVICE.
    - eoi is ignored in REQ, including when it arrives in the same cycle as irq_ack.
  - SERVICE: irq_req=0, busy=1, irq_id held; new requests only accumulate in pending.
    - On eoi, go to IDLE.
    - irq_ack is ignored.
- IDLE with eligible nonzero re-arbitrates on the first cycle back, so irq_req reasserts the cycle after eoi is sampled.
- irq_ack outside REQ and eoi outside SERVICE are ignored.
- A level line that drops while in REQ does not withdraw the request; the CPU still gets irq_id and must ack.
- Outputs irq_req, busy and irq_id are registered and driven directly from the FSM and its id register.

Decomposition:
- Shared package irq_pkg holds:
  - State enum IRQ_IDLE/IRQ_REQ/IRQ_SERVICE (2-bit).
  - Constant IRQ_LINES=4 and IRQ_ID_W=2.
- One natural sub-module: the existing priority_encoder (4-to-2, line 3 highest, with valid).
  - Instantiated on eligible; its valid output gates the IDLE to REQ transition.
- Synchroniser and edge detect are kept inline.

Test Plan:
- Reset, then irq_in=4'b0100 (level, defaults) -> irq_req=1 and irq_id=2'b10 exactly 3 cycles after the first sampling edge; pending=4'b0100.
- irq_in=4'b1010 simultaneously with mask=4'b1000 -> irq_id=2'b01; after irq_ack then eoi, line 3 stays pending but never wins until mask is cleared.
- EDGE_MASK=4'b0001, pulse irq_in[0] for 1 cycle -> pending[0] set and held; ack clears pending[0]; a new edge landing in the ack cycle keeps pending[0]=1.
- In REQ with irq_id=2'b00, raise irq_in[3] -> irq_id stays 2'b00 until ack; after eoi, irq_req reasserts next cycle with irq_id=2'b11.
- Pulse eoi in IDLE and irq_ack in SERVICE -> no state change, busy unchanged.
- Assert rst_n=0 mid-SERVICE -> busy, irq_req and pending drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the 4-line interrupt controller.
package irq_pkg;

  localparam int IRQ_LINES = 4;
  localparam int IRQ_ID_W  = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/priority_encoder.sv
// 4-to-2 priority encoder: line 3 has the highest priority; valid flags any request.
module priority_encoder
  import irq_pkg::*;
(
  input  logic [IRQ_LINES-1:0] req,
  output logic [IRQ_ID_W-1:0]  id,
  output logic                 valid
);

  // Highest-index set bit wins.
  always_comb begin
    id    = 2'd0;
    valid = (req != '0);
    if (req[3])      id = 2'd3;
    else if (req[2]) id = 2'd2;
    else if (req[1]) id = 2'd1;
    else             id = 2'd0;
  end

endmodule

// File: rtl/irq_ctrl4.sv
// 4-line interrupt controller: synchronise, latch pending (edge or level),
// mask, arbitrate and hand the winner to the CPU via req/ack/eoi.
module irq_ctrl4
  import irq_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [IRQ_LINES-1:0] EDGE_MASK   = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_LINES-1:0] irq_in,
  input  logic [IRQ_LINES-1:0] mask,
  input  logic                 irq_ack,
  input  logic                 eoi,
  output logic                 irq_req,
  output logic [IRQ_ID_W-1:0]  irq_id,
  output logic                 busy,
  output logic [IRQ_LINES-1:0] pending
);

  logic [SYNC_STAGES-1:0][IRQ_LINES-1:0] sync_q;
  logic [IRQ_LINES-1:0] sync_s;
  logic [IRQ_LINES-1:0] prev_q;
  logic [IRQ_LINES-1:0] pend_q;
  logic [IRQ_LINES-1:0] pend_next;
  logic [IRQ_LINES-1:0] ack_clr;
  logic [IRQ_LINES-1:0] eligible;
  logic [IRQ_ID_W-1:0]  win_id;
  logic                 win_valid;
  logic                 ack_take;
  irq_state_t           state;
  irq_state_t           next_state;
  logic [IRQ_ID_W-1:0]  next_id;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign ack_take = (state == IRQ_REQ) && irq_ack;
  assign ack_clr  = ack_take ? (IRQ_LINES'(1) << irq_id) : '0;
  // Edge lines: a fresh edge beats a simultaneous ack clear. Level lines track s.
  assign pend_next = (EDGE_MASK & ((sync_s & ~prev_q) | (pend_q & ~ack_clr)))
                   | (~EDGE_MASK & sync_s);
  assign eligible = pend_q & ~mask;
  assign pending  = pend_q;

  // Synchroniser chain, previous-value flop and pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      else                 sync_q <= irq_in;
      prev_q <= sync_s;
      pend_q <= pend_next;
    end
  end

  priority_encoder u_prio (
    .req   (eligible),
    .id    (win_id),
    .valid (win_valid)
  );

  // Next-state and id latch: the id is frozen from REQ until the next IDLE arbitration.
  always_comb begin
    next_state = state;
    next_id    = irq_id;
    case (state)
      IRQ_IDLE: begin
        if (win_valid) begin
          next_state = IRQ_REQ;
          next_id    = win_id;
        end
      end
      IRQ_REQ: begin
        if (irq_ack) next_state = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (eoi) next_state = IRQ_IDLE;
      end
      default: next_state = IRQ_IDLE;
    endcase
  end

  // State, id and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IRQ_IDLE;
      irq_id  <= '0;
      irq_req <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      irq_id  <= next_id;
      irq_req <= (next_state == IRQ_REQ);
      busy    <= (next_state == IRQ_SERVICE);
    end
  end

endmodule

// File: tb/tb_irq_ctrl4.sv
// Bench for irq_ctrl4: a level-triggered instance (2 sync stages) and an
// instance with line 0 edge-triggered (3 sync stages), both tracked by a
// cycle-level behavioural model, plus a vector table and directed sequences.
module tb_irq_ctrl4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in, mask;
  logic       irq_ack, eoi;

  logic       req_l, busy_l, req_e, busy_e;
  logic [1:0] id_l, id_e;
  logic [3:0] pend_l, pend_e;

  always #5 clk = ~clk;

  irq_ctrl4 #(.SYNC_STAGES(2), .EDGE_MASK(4'b0000)) dut_l (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
    .irq_ack(irq_ack), .eoi(eoi), .irq_req(req_l), .irq_id(id_l),
    .busy(busy_l), .pending(pend_l)
  );

  irq_ctrl4 #(.SYNC_STAGES(3), .EDGE_MASK(4'b0001)) dut_e (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
    .irq_ack(irq_ack), .eoi(eoi), .irq_req(req_e), .irq_id(id_e),
    .busy(busy_e), .pending(pend_e)
  );

  // Model: hist[0] is the newest sample of irq_in; mode 0 idle, 1 presenting, 2 in service.
  typedef struct {
    logic [2:0][3:0] hist;
    logic [3:0]      p;
    logic [3:0]      pend;
    logic [3:0]      emask;
    logic [1:0]      mode;
    logic [1:0]      id;
  } model_t;

  typedef struct {
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
  } vec_t;

  int     checks = 0;
  int     failures = 0;
  model_t ml, me;
  vec_t   tbl[12];

  function automatic model_t mreset(input logic [3:0] em);
    model_t m;
    m.hist  = '0;
    m.p     = '0;
    m.pend  = '0;
    m.emask = em;
    m.mode  = 2'd0;
    m.id    = 2'd0;
    return m;
  endfunction

  function automatic model_t mstep(input model_t m, input logic [3:0] in,
                                   input logic [3:0] mk, input logic ak,
                                   input logic eo, input int ss);
    model_t     n;
    logic [3:0] s;
    logic [3:0] elig;
    bit         found;
    n = m;
    s = m.hist[ss-1];
    n.hist = {m.hist[1:0], in};
    n.p = s;
    for (int i = 0; i < 4; i++) begin
      if (m.emask[i])
        n.pend[i] = (s[i] & ~m.p[i]) |
                    (m.pend[i] & !(m.mode == 2'd1 && ak && m.id == 2'(i)));
      else
        n.pend[i] = s[i];
    end
    elig  = m.pend & ~mk;
    found = 1'b0;
    case (m.mode)
      2'd0: begin
        for (int i = 0; i < 4; i++)
          if (elig[i]) begin
            n.id  = 2'(i);
            found = 1'b1;
          end
        if (found) n.mode = 2'd1;
      end
      2'd1: if (ak) n.mode = 2'd2;
      default: if (eo) n.mode = 2'd0;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("l_req",  {3'b0, req_l},  {3'b0, ml.mode == 2'd1});
    chk("l_busy", {3'b0, busy_l}, {3'b0, ml.mode == 2'd2});
    chk("l_id",   {2'b0, id_l},   {2'b0, ml.id});
    chk("l_pend", pend_l, ml.pend);
    chk("e_req",  {3'b0, req_e},  {3'b0, me.mode == 2'd1});
    chk("e_busy", {3'b0, busy_e}, {3'b0, me.mode == 2'd2});
    chk("e_id",   {2'b0, id_e},   {2'b0, me.id});
    chk("e_pend", pend_e, me.pend);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      ml = mstep(ml, irq_in, mask, irq_ack, eoi, 2);
      me = mstep(me, irq_in, mask, irq_ack, eoi, 3);
    end
    #1;
    compare_all();
  endtask

  task automatic ack_cycle();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic eoi_cycle();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    irq_in  = '0;
    mask    = '0;
    irq_ack = 1'b0;
    eoi     = 1'b0;
    ml = mreset(4'b0000);
    me = mreset(4'b0001);
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input bit on_edge_dut, input string nm);
    int n = 0;
    while (!(on_edge_dut ? req_e : req_l) && n < 20) begin
      step();
      n++;
    end
    chk(nm, {3'b0, (on_edge_dut ? req_e : req_l)}, 4'b0001);
  endtask

  initial begin
    rst_n   = 1'b0;
    irq_in  = '0;
    mask    = '0;
    irq_ack = 1'b0;
    eoi     = 1'b0;
    ml = mreset(4'b0000);
    me = mreset(4'b0001);

    tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100};
    tbl[3]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0100};
    tbl[4]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0100};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0100};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};

    // Reset state
    step();
    chk("rst_req",  {3'b0, req_l},  4'b0000);
    chk("rst_busy", {3'b0, busy_l}, 4'b0000);
    chk("rst_id",   {2'b0, id_l},   4'b0000);
    chk("rst_pend", pend_l, 4'b0000);
    rst_n = 1'b1;

    // Vector table on the level instance
    for (int v = 0; v < 12; v++) begin
      irq_in  = tbl[v].irq_in;
      mask    = tbl[v].mask;
      irq_ack = tbl[v].ack;
      eoi     = tbl[v].eoi;
      step();
      chk($sformatf("tbl%0d_req", v),  {3'b0, req_l},  {3'b0, tbl[v].req});
      chk($sformatf("tbl%0d_id", v),   {2'b0, id_l},   {2'b0, tbl[v].id});
      chk($sformatf("tbl%0d_busy", v), {3'b0, busy_l}, {3'b0, tbl[v].busy});
      chk($sformatf("tbl%0d_pend", v), pend_l, tbl[v].pend);
    end
    irq_ack = 1'b0;
    eoi     = 1'b0;

    // Masked line 3 stays pending but never wins until unmasked
    do_reset();
    irq_in = 4'b1010;
    mask   = 4'b1000;
    wait_req(1'b0, "mask_req");
    chk("mask_id", {2'b0, id_l}, 4'd1);
    irq_in = 4'b1000;
    for (int i = 0; i < 3; i++) step();
    chk("level_drop_keeps_req", {3'b0, req_l}, 4'b0001);
    ack_cycle();
    eoi_cycle();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("masked_no_req", {3'b0, req_l}, 4'b0000);
      chk("masked_pend", pend_l, 4'b1000);
    end
    mask = 4'b0000;
    wait_req(1'b0, "unmask_req");
    chk("unmask_id", {2'b0, id_l}, 4'd3);

    // Edge line 0: latch a 1-cycle pulse, ack clears, edge in ack cycle survives
    do_reset();
    irq_in = 4'b0001;
    step();
    irq_in = 4'b0000;
    wait_req(1'b1, "edge_req");
    chk("edge_id", {2'b0, id_e}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("edge_hold", pend_e, 4'b0001);
    end
    ack_cycle();
    chk("edge_ack_clr", pend_e, 4'b0000);
    chk("edge_ack_busy", {3'b0, busy_e}, 4'b0001);
    eoi_cycle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("edge_idle", {3'b0, req_e}, 4'b0000);
    end
    irq_in = 4'b0001;
    step();
    irq_in = 4'b0000;
    wait_req(1'b1, "edge_req2");
    irq_in = 4'b0001;
    step();
    irq_in = 4'b0000;
    step();
    step();
    ack_cycle();
    chk("edge_set_wins", pend_e, 4'b0001);
    chk("edge_set_busy", {3'b0, busy_e}, 4'b0001);
    eoi_cycle();
    chk("edge_eoi_idle", {3'b0, req_e}, 4'b0000);
    step();
    chk("edge_rereq", {3'b0, req_e}, 4'b0001);
    chk("edge_rereq_id", {2'b0, id_e}, 4'd0);

    // No preemption in REQ; ack ignored in SERVICE; re-arbitration after eoi
    do_reset();
    irq_in = 4'b0001;
    wait_req(1'b0, "pre_req");
    chk("pre_id", {2'b0, id_l}, 4'd0);
    irq_in = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pre_hold_id", {2'b0, id_l}, 4'd0);
      chk("pre_hold_req", {3'b0, req_l}, 4'b0001);
    end
    ack_cycle();
    chk("pre_busy", {3'b0, busy_l}, 4'b0001);
    ack_cycle();
    chk("svc_ack_ignored", {3'b0, busy_l}, 4'b0001);
    eoi_cycle();
    chk("post_eoi_req", {3'b0, req_l}, 4'b0000);
    step();
    chk("rearb_req", {3'b0, req_l}, 4'b0001);
    chk("rearb_id", {2'b0, id_l}, 4'd3);

    // Asynchronous reset in the middle of SERVICE
    ack_cycle();
    chk("pre_rst_busy", {3'b0, busy_l}, 4'b0001);
    chk("pre_rst_pend", pend_l, 4'b1001);
    #2;
    rst_n = 1'b0;
    ml = mreset(4'b0000);
    me = mreset(4'b0001);
    #1;
    chk("arst_busy", {3'b0, busy_l}, 4'b0000);
    chk("arst_req",  {3'b0, req_l},  4'b0000);
    chk("arst_pend", pend_l, 4'b0000);
    chk("arst_id",   {2'b0, id_l},   4'b0000);
    compare_all();
    step();
    rst_n = 1'b1;

    // Randomised traffic against the model, with occasional async resets
    irq_in = '0;
    mask   = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) irq_in = 4'($urandom);
      if ($urandom_range(15) == 0) mask = 4'($urandom);
      irq_ack = ($urandom_range(2) == 0);
      eoi     = ($urandom_range(3) == 0);
      step();
      if ($urandom_range(399) == 0) begin
        rst_n = 1'b0;
        ml = mreset(4'b0000);
        me = mreset(4'b0001);
        #1;
        compare_all();
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
